// File: rtl/shift_pipe_if.sv
// Stream interface for the shift_pipe barrel shifter: operand/shamt/mode/tag
// on the input side, result/tag on the output side, each with valid/ready.
interface shift_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter: one registered stage per shift-amount bit,
// largest shift first. Modes: 00 SLL, 01 SRL, 10 SRA, 11 ROR/SRL.
// Optional rotate: define SHIFT_PIPE_ROTATE_EN to make mode 11 rotate right;
// otherwise mode 11 behaves as SRL and no rotate logic exists.
module shift_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input logic         clk,
  input logic         reset,
  shift_pipe_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  logic             vld_p   [SHW];
  logic [WIDTH-1:0] data_p  [SHW];
  logic [TAG_W-1:0] tag_p   [SHW];
  // The last stage needs no shamt/mode/sign copy, so these stop one short.
  logic [SHW-1:0]   shamt_p [SHW-1];
  logic [1:0]       mode_p  [SHW-1];
  logic             sign_p  [SHW-1];
  logic             adv;

  // One fixed-distance shift step; sign is the original operand's MSB.
  function automatic logic [WIDTH-1:0] stage_shift(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       mode,
    input logic             sign,
    input int unsigned      amt
  );
    case (mode)
      2'b00:   stage_shift = d << amt;
      2'b10:   stage_shift = ({WIDTH{sign}} << (WIDTH - amt)) | (d >> amt);
`ifdef SHIFT_PIPE_ROTATE_EN
      2'b11:   stage_shift = (d >> amt) | (d << (WIDTH - amt));
`endif
      default: stage_shift = d >> amt;
    endcase
  endfunction

  // Whole pipeline advances together; stall only when the output is blocked.
  assign adv           = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_p[SHW-1];
  assign bus.out_data  = data_p[SHW-1];
  assign bus.out_tag   = tag_p[SHW-1];

  // Valid, data and tag per stage; cleared by reset so the output reads zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SHW; k++) begin
        vld_p[k]  <= 1'b0;
        data_p[k] <= '0;
        tag_p[k]  <= '0;
      end
    end else if (adv) begin
      // stage 0: shift by WIDTH/2
      vld_p[0]  <= bus.in_valid;
      data_p[0] <= bus.in_shamt[SHW-1]
                   ? stage_shift(bus.in_data, bus.in_mode, bus.in_data[WIDTH-1], WIDTH/2)
                   : bus.in_data;
      tag_p[0]  <= bus.in_tag;
      // stages 1..SHW-1: shift by 2^(SHW-1-k)
      for (int k = 1; k < SHW; k++) begin
        vld_p[k]  <= vld_p[k-1];
        data_p[k] <= shamt_p[k-1][SHW-1-k]
                     ? stage_shift(data_p[k-1], mode_p[k-1], sign_p[k-1], 1 << (SHW-1-k))
                     : data_p[k-1];
        tag_p[k]  <= tag_p[k-1];
      end
    end
  end

  // Shift amount, mode and original sign travel with the beat; no reset needed.
  always_ff @(posedge clk) begin
    if (adv) begin
      shamt_p[0] <= bus.in_shamt;
      mode_p[0]  <= bus.in_mode;
      sign_p[0]  <= bus.in_data[WIDTH-1];
      for (int k = 1; k < SHW-1; k++) begin
        shamt_p[k] <= shamt_p[k-1];
        mode_p[k]  <= mode_p[k-1];
        sign_p[k]  <= sign_p[k-1];
      end
    end
  end
endmodule

// File: tb/tb_shift_pipe.sv
// Testbench for shift_pipe (WIDTH=32, TAG_W=5): scoreboard against a
// plain-arithmetic shift model plus directed literal checks.
module tb_shift_pipe;
  localparam int W  = 32;
  localparam int TW = 5;
  localparam int SHW = 5;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   n_out = 0;

  logic [W+TW-1:0] exp_q[$];
  logic            prev_stall;
  logic [W-1:0]    prev_d;
  logic [TW-1:0]   prev_t;

  shift_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus ();

  shift_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endfunction

  // Reference shift straight from the mode definitions.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int s, input logic [1:0] m);
    logic [2*W-1:0] dd;
    case (m)
      2'd0: return d << s;
      2'd1: return d >> s;
      2'd2: return W'($signed(d) >>> s);
      default: begin
`ifdef SHIFT_PIPE_ROTATE_EN
        dd = {d, d} >> s;
        return dd[W-1:0];
`else
        dd = {{W{1'b0}}, d} >> s;
        return dd[W-1:0];
`endif
      end
    endcase
  endfunction

  // Scoreboard: values at the falling edge are what the next rising edge acts on.
  always @(negedge clk) begin
    logic [W+TW-1:0] e;
    if (reset) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 64'(bus.out_valid), 64'd1);
        chk("hold_data", 64'(bus.out_data), 64'(prev_d));
        chk("hold_tag", 64'(bus.out_tag), 64'(prev_t));
      end
      chk("in_ready", 64'(bus.in_ready), 64'(!(bus.out_valid && !bus.out_ready)));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat_tag", 64'(bus.out_tag), 64'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", 64'(bus.out_data), 64'(e[W-1:0]));
          chk("sb_tag", 64'(bus.out_tag), 64'(e[W+TW-1:W]));
          n_out++;
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back({bus.in_tag, ref_shift(bus.in_data, int'(bus.in_shamt), bus.in_mode)});
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_d     = bus.out_data;
      prev_t     = bus.out_tag;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input int s, input logic [1:0] m, input logic [TW-1:0] t);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_shamt = SHW'(s);
    bus.in_mode  = m;
    bus.in_tag   = t;
  endtask

  // One clock; reports whether the beat on the inputs was taken at this edge.
  task automatic cycle(output bit acc);
    @(negedge clk);
    acc = bus.in_valid && bus.in_ready && !reset;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 60) begin
      step();
      n++;
    end
    chk("drain_timeout", 64'(n < 60), 64'd1);
  endtask

  // Single beat on an idle pipeline: latency, literal result, one-cycle pulse.
  task automatic single(input string nm, input logic [W-1:0] d, input int s,
                        input logic [1:0] m, input logic [TW-1:0] t, input logic [W-1:0] req);
    int lat = 0;
    bus.out_ready = 1'b1;
    drive(1'b1, d, s, m, t);
    step();
    lat = 1;
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk({nm, "_lat"}, 64'(lat), 64'(SHW));
    chk({nm, "_data"}, 64'(bus.out_data), 64'(req));
    chk({nm, "_tag"}, 64'(bus.out_tag), 64'(t));
    step();
    chk({nm, "_pulse"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    bit acc;
    int idx, c, n, n0;
    logic [W-1:0] rot_req;

    reset = 1'b1;
    bus.out_ready = 1'b0;
    drive(1'b0, '0, 0, 2'd0, '0);
    repeat (3) step();
    reset = 1'b0;
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_data", 64'(bus.out_data), 64'd0);
    chk("rst_tag", 64'(bus.out_tag), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    single("sll16", 32'h0000ABCD, 16, 2'd0, 5'd3, 32'hABCD0000);

    // Back-to-back SRA then SRL of the same operand.
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h80000000, 31, 2'd2, 5'd1);
    step();
    drive(1'b1, 32'h80000000, 31, 2'd1, 5'd2);
    step();
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      step();
      n++;
    end
    chk("b2b_sra_data", 64'(bus.out_data), 64'hFFFFFFFF);
    chk("b2b_sra_tag", 64'(bus.out_tag), 64'd1);
    step();
    chk("b2b_srl_valid", 64'(bus.out_valid), 64'd1);
    chk("b2b_srl_data", 64'(bus.out_data), 64'h00000001);
    chk("b2b_srl_tag", 64'(bus.out_tag), 64'd2);
    drain();

    single("sh0_sll", 32'hDEADBEEF, 0, 2'd0, 5'd4, 32'hDEADBEEF);
    single("sh0_srl", 32'hDEADBEEF, 0, 2'd1, 5'd5, 32'hDEADBEEF);
    single("sh0_sra", 32'hDEADBEEF, 0, 2'd2, 5'd6, 32'hDEADBEEF);
    single("sh0_m11", 32'hDEADBEEF, 0, 2'd3, 5'd7, 32'hDEADBEEF);
    single("sra_pos", 32'h7FFFFFF0, 4, 2'd2, 5'd8, 32'h07FFFFFF);
    single("sra_neg", 32'hF0000000, 3, 2'd2, 5'd9, 32'hFE000000);
`ifdef SHIFT_PIPE_ROTATE_EN
    rot_req = 32'h78123456;
`else
    rot_req = 32'h00123456;
`endif
    single("mode11_8", 32'h12345678, 8, 2'd3, 5'd10, rot_req);

    // Eight tagged beats with the consumer stalling mid-stream.
    n0 = n_out;
    idx = 0;
    c = 0;
    drive(1'b1, $urandom, int'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 5'd0);
    while (idx < 8 && c < 100) begin
      bus.out_ready = !(c >= 6 && c <= 8);
      cycle(acc);
      if (acc) begin
        idx++;
        drive(idx < 8, $urandom, int'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), TW'(idx));
      end
      c++;
    end
    drain();
    chk("stream8_count", 64'(n_out - n0), 64'd8);

    // Random traffic with random back-pressure.
    drive(1'b1, $urandom, int'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), TW'($urandom));
    for (int i = 0; i < 400; i++) begin
      bus.out_ready = ($urandom_range(0, 9) < 7);
      cycle(acc);
      if (acc || !bus.in_valid)
        drive($urandom_range(0, 9) < 7, $urandom, int'($urandom_range(0, 31)),
              2'($urandom_range(0, 3)), TW'($urandom));
    end
    drain();

    // Fill with five beats, then reset for one cycle.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, $urandom | 32'h1, 0, 2'd0, TW'(i + 1));
      cycle(acc);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_data", 64'(bus.out_data), 64'd0);
    chk("mid_rst_tag", 64'(bus.out_tag), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("post_rst_quiet", 64'(bus.out_valid), 64'd0);
    end

    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
